// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding, grant encoding and bus widths for the memory bus arbiter
package mem_bus_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      D_ADDR = 3'd1,
      D_WAIT = 3'd2,
      I_ADDR = 3'd3,
      I_WAIT = 3'd4
   } state_t;
   localparam logic GRANT_DATA = 1'b1;
   localparam logic GRANT_INST = 1'b0;
   localparam int BUS_DATA_W = 32;
   localparam int BUS_BE_W = BUS_DATA_W / 8;
   function automatic logic is_inst(state_t s);
      return (s == I_ADDR) || (s == I_WAIT);
   endfunction
endpackage

// File: rtl/mem_bus_grant.sv
// mem_bus_grant: picks data or fetch in IDLE, letting fetch win once after a data grant
module mem_bus_grant
   import mem_bus_pkg::*;
(
   input  logic inst_req,
   input  logic data_req,
   input  logic inst_mask,
   input  logic data_mask,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt_side
);
   logic iv, dv;
   always_comb begin
      iv = inst_req & ~inst_mask;
      dv = data_req & ~data_mask;
      gnt_valid = iv | dv;
      gnt_side = (dv && (!iv || last_grant == GRANT_INST)) ? GRANT_DATA : GRANT_INST;
   end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one req/addr_ok/data_ok memory bus between fetch and data, one transaction at a time
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = BUS_DATA_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_done,
   output logic [DATA_W-1:0]   inst_rdata,
   input  logic                data_req,
   input  logic                data_wr,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W/8-1:0] data_be,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_done,
   output logic [DATA_W-1:0]   data_rdata,
   input  logic                flush,
   output logic                bus_req,
   output logic                bus_wr,
   output logic [DATA_W/8-1:0] bus_be,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_addr_ok,
   input  logic                bus_data_ok,
   input  logic [DATA_W-1:0]   bus_rdata,
   output logic                busy
);
   state_t state, state_d;
   logic last_grant, cancel_q, cancel_d;
   logic gnt_valid, gnt_side, grant_go, inst_fin, data_fin;

   // a side's request is masked in its own done cycle so a held req is not re-granted
   mem_bus_grant u_grant (
      .inst_req  (inst_req),
      .data_req  (data_req),
      .inst_mask (inst_done),
      .data_mask (data_done),
      .last_grant(last_grant),
      .gnt_valid (gnt_valid),
      .gnt_side  (gnt_side)
   );

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = gnt_valid ? ((gnt_side == GRANT_DATA) ? D_ADDR : I_ADDR) : IDLE;
         D_ADDR:  state_d = bus_addr_ok ? D_WAIT : D_ADDR;
         I_ADDR:  state_d = bus_addr_ok ? I_WAIT : I_ADDR;
         D_WAIT:  state_d = bus_data_ok ? IDLE : D_WAIT;
         I_WAIT:  state_d = bus_data_ok ? IDLE : I_WAIT;
         default: state_d = IDLE;
      endcase
      grant_go = (state == IDLE) && gnt_valid;
      // a flush arriving with the response still cancels that response
      inst_fin = (state == I_WAIT) && bus_data_ok && !(cancel_q || flush);
      data_fin = (state == D_WAIT) && bus_data_ok;
      cancel_d = is_inst(state_d) && (cancel_q || (flush && is_inst(state)));
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= GRANT_INST;
         cancel_q   <= 1'b0;
         bus_req    <= 1'b0;
         bus_wr     <= 1'b0;
         bus_be     <= '0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         inst_done  <= 1'b0;
         data_done  <= 1'b0;
         inst_rdata <= '0;
         data_rdata <= '0;
      end else begin
         state     <= state_d;
         cancel_q  <= cancel_d;
         bus_req   <= (state_d == D_ADDR) || (state_d == I_ADDR);
         inst_done <= inst_fin;
         data_done <= data_fin;
         if (grant_go) begin
            last_grant <= gnt_side;
            bus_wr     <= (gnt_side == GRANT_DATA) && data_wr;
            bus_be     <= (gnt_side == GRANT_DATA) ? data_be : '1;
            bus_addr   <= (gnt_side == GRANT_DATA) ? data_addr : inst_addr;
            bus_wdata  <= (gnt_side == GRANT_DATA) ? data_wdata : '0;
         end
         if (inst_fin) inst_rdata <= bus_rdata;
         if (data_fin) data_rdata <= bus_rdata;
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed cycle-accurate checks of the memory bus arbiter
module tb_mem_bus_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic inst_req, inst_done, data_req, data_wr, data_done, flush;
   logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
   logic [3:0] data_be, bus_be;
   logic bus_req, bus_wr, bus_addr_ok, bus_data_ok, busy;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_inst, exp_data;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_done(inst_done), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_be(data_be),
      .data_wdata(data_wdata), .data_done(data_done), .data_rdata(data_rdata),
      .flush(flush),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
      .busy(busy)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_addr = 0;
      data_be = 0; data_wdata = 0; flush = 0;
      bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
   endtask

   task automatic test_reset();
      reset = 1; idle_inputs(); step(); step();
      n_cmp++;
      if ({bus_req, bus_wr, bus_be, bus_addr, bus_wdata, inst_done, data_done, inst_rdata, data_rdata, busy} !== '0) begin
         n_bad++;
         $display("FAIL reset_values: got req=%b wr=%b be=%h addr=%h wd=%h idone=%b ddone=%b ird=%h drd=%h busy=%b, want all 0",
                  bus_req, bus_wr, bus_be, bus_addr, bus_wdata, inst_done, data_done, inst_rdata, data_rdata, busy);
      end
      reset = 0; exp_inst = 0; exp_data = 0; step();
   endtask

   task automatic test_load();
      data_req = 1; data_wr = 0; data_addr = 32'h100; step();
      n_cmp++;
      if ({bus_req, bus_wr, busy, bus_addr} !== {1'b1, 1'b0, 1'b1, 32'h100}) begin
         n_bad++; $display("FAIL load_req_c1: got req=%b wr=%b busy=%b addr=%h, want 1 0 1 00000100", bus_req, bus_wr, busy, bus_addr);
      end
      bus_addr_ok = 1; step(); bus_addr_ok = 0;
      for (int c = 2; c < 5; c++) begin
         n_cmp++;
         if ({bus_req, data_done, busy} !== 3'b001) begin
            n_bad++; $display("FAIL load_wait_c%0d: got req=%b done=%b busy=%b, want 0 0 1", c, bus_req, data_done, busy);
         end
         if (c == 4) begin bus_data_ok = 1; bus_rdata = 32'hDEADBEEF; end
         step();
      end
      bus_data_ok = 0; bus_rdata = 0;
      n_cmp++;
      if ({data_done, busy, data_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
         n_bad++; $display("FAIL load_done_c5: got done=%b busy=%b rdata=%h, want 1 0 deadbeef", data_done, busy, data_rdata);
      end
      exp_data = 32'hDEADBEEF;
      step(); data_req = 0;
      n_cmp++;
      if ({data_done, bus_req, busy} !== 3'b000) begin
         n_bad++; $display("FAIL load_req_masked: got done=%b req=%b busy=%b, want 0 0 0", data_done, bus_req, busy);
      end
   endtask

   task automatic test_store();
      data_req = 1; data_wr = 1; data_addr = 32'h204; data_be = 4'b0011; data_wdata = 32'h1234; step();
      for (int c = 1; c < 5; c++) begin
         n_cmp++;
         if ({bus_req, bus_wr, bus_be, bus_addr, bus_wdata} !== {1'b1, 1'b1, 4'h3, 32'h204, 32'h1234}) begin
            n_bad++; $display("FAIL store_hold_c%0d: got req=%b wr=%b be=%h addr=%h wd=%h, want 1 1 3 00000204 00001234",
                              c, bus_req, bus_wr, bus_be, bus_addr, bus_wdata);
         end
         if (c == 4) bus_addr_ok = 1;
         step();
      end
      bus_addr_ok = 0;
      n_cmp++;
      if ({bus_req, data_done} !== 2'b00) begin
         n_bad++; $display("FAIL store_req_drop: got req=%b done=%b, want 0 0", bus_req, data_done);
      end
      bus_data_ok = 1; step(); bus_data_ok = 0;
      n_cmp++;
      if ({data_done, busy} !== 2'b10) begin
         n_bad++; $display("FAIL store_done: got done=%b busy=%b, want 1 0", data_done, busy);
      end
      step(); data_req = 0; data_wr = 0; data_be = 0; data_wdata = 0; step();
   endtask

   task automatic test_alternation();
      int ng = 0;
      int n_dd = 0;
      int n_id = 0;
      logic ok_next = 0;
      logic cur_data = 0;
      logic [31:0] pend_val = 0;
      reset = 1; step(); reset = 0;
      data_req = 1; data_wr = 0; data_addr = 32'h300; inst_req = 1; inst_addr = 32'h400;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (data_done) begin
            n_dd++; n_cmp++;
            if ({cur_data, data_rdata} !== {1'b1, pend_val}) begin
               n_bad++; $display("FAIL alt_data_done: got side_data=%b rdata=%h, want 1 %h", cur_data, data_rdata, pend_val);
            end
            exp_data = pend_val;
         end
         if (inst_done) begin
            n_id++; n_cmp++;
            if ({cur_data, inst_rdata} !== {1'b0, pend_val}) begin
               n_bad++; $display("FAIL alt_inst_done: got side_data=%b rdata=%h, want 0 %h", cur_data, inst_rdata, pend_val);
            end
            exp_inst = pend_val;
            if (ng >= 6) inst_req = 0;
         end
         if (bus_req) begin
            n_cmp++;
            if (bus_addr !== ((ng % 2 == 0) ? 32'h300 : 32'h400) || cyc != 1 + 3 * ng) begin
               n_bad++; $display("FAIL alt_grant%0d: got addr=%h at cycle %0d, want %h at cycle %0d",
                                 ng, bus_addr, cyc, (ng % 2 == 0) ? 32'h300 : 32'h400, 1 + 3 * ng);
            end
            cur_data = (bus_addr == 32'h300);
            ng++;
            if (ng == 6) data_req = 0;
         end
         bus_data_ok = ok_next;
         if (ok_next) begin pend_val = 32'hA000_0000 + ng; bus_rdata = pend_val; end
         ok_next = bus_req;
         bus_addr_ok = bus_req;
         step();
      end
      idle_inputs();
      n_cmp++;
      if (ng != 6 || n_dd != 3 || n_id != 3) begin
         n_bad++; $display("FAIL alt_counts: got grants=%0d data_done=%0d inst_done=%0d, want 6 3 3", ng, n_dd, n_id);
      end
   endtask

   task automatic test_flush();
      inst_req = 1; inst_addr = 32'hBFC00000; step();
      n_cmp++;
      if ({bus_req, bus_wr, bus_be, bus_addr} !== {1'b1, 1'b0, 4'hF, 32'hBFC00000}) begin
         n_bad++; $display("FAIL flush_fetch_req: got req=%b wr=%b be=%h addr=%h, want 1 0 f bfc00000", bus_req, bus_wr, bus_be, bus_addr);
      end
      bus_addr_ok = 1; step(); bus_addr_ok = 0;
      flush = 1; inst_req = 0; step();
      flush = 0; bus_data_ok = 1; bus_rdata = 32'h0; step(); bus_data_ok = 0;
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if ({inst_done, busy, bus_req, inst_rdata} !== {3'b000, exp_inst}) begin
            n_bad++; $display("FAIL flush_cancel%0d: got done=%b busy=%b req=%b rdata=%h, want 0 0 0 %h", c, inst_done, busy, bus_req, inst_rdata, exp_inst);
         end
         step();
      end
      inst_req = 1; inst_addr = 32'hBFC00380; step();
      n_cmp++;
      if ({bus_req, bus_addr} !== {1'b1, 32'hBFC00380}) begin
         n_bad++; $display("FAIL flush_next_req: got req=%b addr=%h, want 1 bfc00380", bus_req, bus_addr);
      end
      bus_addr_ok = 1; step(); bus_addr_ok = 0;
      bus_data_ok = 1; bus_rdata = 32'h3C080000; step(); bus_data_ok = 0;
      n_cmp++;
      if ({inst_done, inst_rdata} !== {1'b1, 32'h3C080000}) begin
         n_bad++; $display("FAIL flush_next_done: got done=%b rdata=%h, want 1 3c080000", inst_done, inst_rdata);
      end
      exp_inst = 32'h3C080000;
      inst_addr = 32'hBFC00400; step();
      n_cmp++;
      if ({bus_req, inst_done} !== 2'b00) begin
         n_bad++; $display("FAIL flush_req_masked: got req=%b done=%b, want 0 0", bus_req, inst_done);
      end
      step(); bus_addr_ok = 1; step(); bus_addr_ok = 0; inst_req = 0;
      bus_data_ok = 1; flush = 1; bus_rdata = 32'h1111; step(); bus_data_ok = 0; flush = 0;
      n_cmp++;
      if ({inst_done, busy, inst_rdata} !== {2'b00, exp_inst}) begin
         n_bad++; $display("FAIL flush_with_data_ok: got done=%b busy=%b rdata=%h, want 0 0 %h", inst_done, busy, inst_rdata, exp_inst);
      end
      step();
   endtask

   task automatic test_reset_mid();
      data_req = 1; data_wr = 0; data_addr = 32'h500; step();
      bus_addr_ok = 1; step(); bus_addr_ok = 0;
      reset = 1; step(); reset = 0; data_req = 0;
      n_cmp++;
      if ({bus_req, busy, data_done, inst_done, data_rdata, inst_rdata, bus_addr} !== '0) begin
         n_bad++; $display("FAIL reset_mid: got req=%b busy=%b ddone=%b idone=%b drd=%h ird=%h addr=%h, want all 0",
                           bus_req, busy, data_done, inst_done, data_rdata, inst_rdata, bus_addr);
      end
      step();
      n_cmp++;
      if ({data_done, busy} !== 2'b00) begin
         n_bad++; $display("FAIL reset_mid_after: got done=%b busy=%b, want 0 0", data_done, busy);
      end
      flush = 1; data_req = 1; data_addr = 32'h600; step();
      n_cmp++;
      if ({bus_req, bus_addr} !== {1'b1, 32'h600}) begin
         n_bad++; $display("FAIL reset_mid_load_req: got req=%b addr=%h, want 1 00000600", bus_req, bus_addr);
      end
      bus_addr_ok = 1; step(); bus_addr_ok = 0;
      bus_data_ok = 1; bus_rdata = 32'h55AA; step(); bus_data_ok = 0;
      n_cmp++;
      if ({data_done, data_rdata} !== {1'b1, 32'h55AA}) begin
         n_bad++; $display("FAIL reset_mid_load_done: got done=%b rdata=%h, want 1 000055aa", data_done, data_rdata);
      end
      exp_data = 32'h55AA; exp_inst = 0;
      step(); data_req = 0; flush = 0; step();
   endtask

   task automatic test_spurious();
      bus_data_ok = 1; bus_addr_ok = 1; bus_rdata = 32'hBAD; step(); bus_data_ok = 0; bus_addr_ok = 0;
      n_cmp++;
      if ({busy, bus_req, data_done, inst_done, data_rdata, inst_rdata} !== {4'b0000, exp_data, exp_inst}) begin
         n_bad++; $display("FAIL spurious_idle: got busy=%b req=%b ddone=%b idone=%b drd=%h ird=%h, want 0 0 0 0 %h %h",
                           busy, bus_req, data_done, inst_done, data_rdata, inst_rdata, exp_data, exp_inst);
      end
      data_req = 1; data_addr = 32'h700; step();
      bus_data_ok = 1; step(); bus_data_ok = 0;
      n_cmp++;
      if ({bus_req, data_done, data_rdata} !== {2'b10, exp_data}) begin
         n_bad++; $display("FAIL spurious_addr_state: got req=%b done=%b rdata=%h, want 1 0 %h", bus_req, data_done, data_rdata, exp_data);
      end
      bus_addr_ok = 1; step(); bus_addr_ok = 0;
      bus_data_ok = 1; bus_rdata = 32'h777; step(); bus_data_ok = 0;
      n_cmp++;
      if ({data_done, data_rdata} !== {1'b1, 32'h777}) begin
         n_bad++; $display("FAIL spurious_then_load: got done=%b rdata=%h, want 1 00000777", data_done, data_rdata);
      end
      step(); data_req = 0; step();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_load();
      test_store();
      test_alternation();
      test_flush();
      test_reset_mid();
      test_spurious();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
